// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter for one synchronous-read data memory port.
//
// Requester 0 is normally the CPU data path and requester 1 a second bus master.
// At most one beat is granted per cycle. Idle ties are broken round-robin. A
// requester may hold ownership with lock for up to MAX_LOCK back-to-back beats.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rN_req/lock/we/addr/wdata requester N beat request, lock hint and payload
//   rN_gnt                    requester N beat accepted this cycle (combinational)
//   rN_rvalid/rN_rdata        requester N read return, one cycle after gnt
//   mem_we/addr/wdata         memory command for the granted beat (zero when idle)
//   mem_rdata                 memory read data, valid the cycle after the address
module mem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r0_lock,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_lock,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LockMax = CW'(MAX_LOCK);
    // With a single-beat limit the lock can never carry past the first beat.
    localparam bit LockAllowed = (MAX_LOCK > 1);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    state_e        r_state, w_state_d;
    logic          r_prio, w_prio_d;
    logic [CW-1:0] r_lock_cnt, w_lock_cnt_d;
    logic [CW-1:0] w_cnt_inc;
    logic          w_gnt0, w_gnt1;
    logic          r_rvalid0, r_rvalid1;

    assign w_cnt_inc = r_lock_cnt + CW'(1);

    always_comb begin
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_state_d    = r_state;
        w_prio_d     = r_prio;
        w_lock_cnt_d = r_lock_cnt;
        if (!rst) begin
            case (r_state)
                StIdle: begin
                    if (r0_req && (!r1_req || !r_prio)) begin
                        w_gnt0   = 1'b1;
                        w_prio_d = 1'b1;
                        if (r0_lock && LockAllowed) begin
                            w_state_d    = StOwn0;
                            w_lock_cnt_d = CW'(1);
                        end else begin
                            w_lock_cnt_d = '0;
                        end
                    end else if (r1_req) begin
                        w_gnt1   = 1'b1;
                        w_prio_d = 1'b0;
                        if (r1_lock && LockAllowed) begin
                            w_state_d    = StOwn1;
                            w_lock_cnt_d = CW'(1);
                        end else begin
                            w_lock_cnt_d = '0;
                        end
                    end
                end
                StOwn0: begin
                    if (r0_req) begin
                        w_gnt0   = 1'b1;
                        w_prio_d = 1'b1;
                        if (!r0_lock || (w_cnt_inc == LockMax)) begin
                            w_state_d    = StIdle;
                            w_lock_cnt_d = '0;
                        end else begin
                            w_lock_cnt_d = w_cnt_inc;
                        end
                    end else begin
                        // Voluntary release: no beat this cycle, prio left alone.
                        w_state_d    = StIdle;
                        w_lock_cnt_d = '0;
                    end
                end
                StOwn1: begin
                    if (r1_req) begin
                        w_gnt1   = 1'b1;
                        w_prio_d = 1'b0;
                        if (!r1_lock || (w_cnt_inc == LockMax)) begin
                            w_state_d    = StIdle;
                            w_lock_cnt_d = '0;
                        end else begin
                            w_lock_cnt_d = w_cnt_inc;
                        end
                    end else begin
                        w_state_d    = StIdle;
                        w_lock_cnt_d = '0;
                    end
                end
                default: begin
                    w_state_d    = StIdle;
                    w_lock_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt0) begin
            mem_we    = r0_we;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
        end else if (w_gnt1) begin
            mem_we    = r1_we;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_prio     <= 1'b0;
            r_lock_cnt <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_prio     <= w_prio_d;
            r_lock_cnt <= w_lock_cnt_d;
            r_rvalid0  <= w_gnt0 & ~r0_we;
            r_rvalid1  <= w_gnt1 & ~r1_we;
        end
    end

    assign r0_gnt    = w_gnt0;
    assign r1_gnt    = w_gnt1;
    // Masked by rst so a read granted just before reset never shows a valid
    // while reset is held or afterwards.
    assign r0_rvalid = r_rvalid0 & ~rst;
    assign r1_rvalid = r_rvalid1 & ~rst;
    assign r0_rdata  = mem_rdata;
    assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_req, r0_lock, r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt, r0_rvalid;
    logic [DW-1:0] r0_rdata;
    logic          r1_req, r1_lock, r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt, r1_rvalid;
    logic [DW-1:0] r1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] model_mem [0:255];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    mem_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .MAX_LOCK(ML)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .r0_req   (r0_req),
        .r0_lock  (r0_lock),
        .r0_we    (r0_we),
        .r0_addr  (r0_addr),
        .r0_wdata (r0_wdata),
        .r0_gnt   (r0_gnt),
        .r0_rvalid(r0_rvalid),
        .r0_rdata (r0_rdata),
        .r1_req   (r1_req),
        .r1_lock  (r1_lock),
        .r1_we    (r1_we),
        .r1_addr  (r1_addr),
        .r1_wdata (r1_wdata),
        .r1_gnt   (r1_gnt),
        .r1_rvalid(r1_rvalid),
        .r1_rdata (r1_rdata),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return 16'hC000 | 16'(i * 7);
    endfunction

    // Synchronous-read memory behind the arbiter; refilled while rst is high.
    logic [DW-1:0] mem_arr [0:255];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
        end else if (mem_we) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= mem_arr[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic req, input logic lock, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        r0_req = req; r0_lock = lock; r0_we = we; r0_addr = addr; r0_wdata = wdata;
    endtask

    task automatic drive1(input logic req, input logic lock, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        r1_req = req; r1_lock = lock; r1_we = we; r1_addr = addr; r1_wdata = wdata;
    endtask

    // One clock cycle: inputs are already driven; sample at negedge, check
    // grants, mux and read returns, then advance the model to the next cycle.
    task automatic tick(input string tag, input logic eg0, input logic eg1);
        logic          ev0, ev1, ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd;
        @(negedge clk);
        ev0 = (q0.size() != 0) && !rst;
        ev1 = (q1.size() != 0) && !rst;
        chk({tag, ".gnt0"}, 32'(r0_gnt), 32'(eg0));
        chk({tag, ".gnt1"}, 32'(r1_gnt), 32'(eg1));
        chk({tag, ".rv0"}, 32'(r0_rvalid), 32'(ev0));
        chk({tag, ".rv1"}, 32'(r1_rvalid), 32'(ev1));
        if (ev0) chk({tag, ".rdata0"}, 32'(r0_rdata), 32'(q0[0]));
        if (ev1) chk({tag, ".rdata1"}, 32'(r1_rdata), 32'(q1[0]));
        q0.delete();
        q1.delete();
        ewe = 1'b0; eaddr = '0; ewd = '0;
        if (eg0) begin
            ewe = r0_we; eaddr = r0_addr; ewd = r0_wdata;
        end else if (eg1) begin
            ewe = r1_we; eaddr = r1_addr; ewd = r1_wdata;
        end
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(ewe));
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(eaddr));
        chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(ewd));
        if (rst) begin
            for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
        end else begin
            if (eg0 && !r0_we) q0.push_back(model_mem[r0_addr[7:0]]);
            if (eg1 && !r1_we) q1.push_back(model_mem[r1_addr[7:0]]);
            if (eg0 && r0_we) model_mem[r0_addr[7:0]] = r0_wdata;
            if (eg1 && r1_we) model_mem[r1_addr[7:0]] = r1_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
        rst = 1'b1;
        drive0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        drive1(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
        @(posedge clk);
        #1;

        // Reset held two cycles with both requesting.
        tick("rst_a", 1'b0, 1'b0);
        tick("rst_b", 1'b0, 1'b0);
        rst = 1'b0;

        // Round-robin contention, r0 first since prio resets to 0.
        for (int k = 0; k < 6; k++) begin
            tick($sformatf("rr%0d", k), (k % 2) == 0, (k % 2) == 1);
        end
        drive0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick("rr_idle", 1'b0, 1'b0);

        // Lone r0 beat moves prio to 1, then r1 locks against a waiting r0.
        drive0(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
        tick("lk_pre", 1'b1, 1'b0);
        drive0(1'b1, 1'b0, 1'b0, 16'h0041, 16'h0000);
        drive1(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000);
        for (int k = 0; k < ML; k++) tick($sformatf("lk%0d", k), 1'b0, 1'b1);
        tick("lk_release", 1'b1, 1'b0);
        drive0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick("lk_idle", 1'b0, 1'b0);

        // Voluntary release: r0 locks for 2 beats, then drops req.
        drive0(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0000);
        tick("vr0", 1'b1, 1'b0);
        drive1(1'b1, 1'b0, 1'b0, 16'h0060, 16'h0000);
        tick("vr1", 1'b1, 1'b0);
        drive0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick("vr_drop", 1'b0, 1'b0);
        tick("vr_r1", 1'b0, 1'b1);
        drive1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Write path, then read the written word back through r0.
        drive1(1'b1, 1'b0, 1'b1, 16'h1234, 16'hBEEF);
        tick("wr", 1'b0, 1'b1);
        drive1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive0(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
        tick("wr_rb", 1'b1, 1'b0);
        drive0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick("wr_idle", 1'b0, 1'b0);

        // Reset while r1 owns the port with lock_cnt = 2.
        drive1(1'b1, 1'b1, 1'b0, 16'h0070, 16'h0000);
        tick("rml0", 1'b0, 1'b1);
        tick("rml1", 1'b0, 1'b1);
        drive0(1'b1, 1'b0, 1'b0, 16'h0080, 16'h0000);
        rst = 1'b1;
        tick("rml_rst", 1'b0, 1'b0);
        rst = 1'b0;
        tick("rml_after", 1'b1, 1'b0);
        tick("rml_next", 1'b0, 1'b1);
        drive0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick("end_idle", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single synchronous-read data memory port between the CPU data path (requester 0) and a second bus master such as a program loader or display DMA (requester 1). It sits between the requesters and the memory, choosing at most one access per cycle. The default policy is round-robin. A bounded lock lets one master issue back-to-back beats, and read data returns with fixed one-cycle latency.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width
- MAX_LOCK, 8, maximum consecutive granted beats under lock (≥1)

Ports:
- clk  in  1  clock; all state updates on posedge clk
- rst  in  1  reset, synchronous, active-high
- r0_req  in  1  requester 0 access request
- r0_lock  in  1  requester 0 wants to keep ownership after this beat
- r0_we  in  1  requester 0 write (1) / read (0)
- r0_addr  in  AW  requester 0 address
- r0_wdata  in  DW  requester 0 write data
- r0_gnt  out  1  requester 0 beat accepted this cycle (combinational)
- r0_rvalid  out  1  requester 0 read data valid (registered)
- r0_rdata  out  DW  requester 0 read data
- r1_*  same set for requester 1
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after the address is presented

## Operation
- State: fsm ∈ {IDLE, OWN0, OWN1}, prio bit (requester to favour on a tie), lock_cnt (counts 0..MAX_LOCK).
- Grant, IDLE:
  - Only one req high: grant it.
  - Both high: grant requester `prio`.
- Grant, OWNn: grant only rn, and only if rn_req is high. The other requester is never granted, even when rn_req is low.
- At most one gnt per cycle. gnt = 0 whenever rst = 1.
- Memory mux:
  - Granted requester's we/addr/wdata drive the mem_* outputs.
  - No grant: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Read return:
  - rN_rvalid <= rN_gnt & ~rN_we.
  - r0_rdata = r1_rdata = mem_rdata, passed through. It is meaningful only while the matching rvalid is high.
- Writes produce no rvalid.
- Transitions on a cycle where requester n is granted:
  - From IDLE with rn_lock = 1 → OWNn, lock_cnt = 1.
  - From IDLE with rn_lock = 0 → stay IDLE.
  - In all cases prio ← other requester (1−n).
- OWNn, granted beat:
  - lock_cnt increments.
  - Exit to IDLE if rn_lock = 0, or if the incremented count equals MAX_LOCK (forced release).
- OWNn, rn_req = 0: → IDLE immediately, lock_cnt ← 0. This is a voluntary release; prio is unchanged.
- Every entry to IDLE clears lock_cnt.
- With MAX_LOCK = 1, lock never holds past the first beat: the master stays in IDLE and lock_cnt stays 0.
- Requests are level-based. A requester holds req, we, addr and wdata stable until it sees gnt. There is no request queue.

## Timing
- Grant is zero-latency: gnt and the mem_* outputs are valid in the same cycle as req. The memory samples on the next posedge.
- Read latency is 1 cycle: rvalid and rdata appear the cycle after gnt.
- Sustained throughput is one beat per cycle. Back-to-back reads from alternating requesters each get rvalid exactly one cycle after their own gnt.
- Reset values: fsm = IDLE, prio = 0, lock_cnt = 0, r0_rvalid = r1_rvalid = 0. During rst both gnt = 0 and mem_we = 0.
- Reset mid-lock: the arbiter returns to IDLE with prio = 0. A read granted in the cycle before rst rises does not produce rvalid after reset.
- Starvation bound: under contention a requester waits at most MAX_LOCK cycles before it is granted.

## Test plan
- Reset: hold rst 2 cycles with both req high → gnt = 0, mem_we = 0, rvalid = 0. First cycle after reset → r0_gnt = 1 (prio = 0).
- Contention round-robin: r0_req = r1_req = 1, lock = 0, reads to 0x0010 / 0x0020 for 6 cycles → grants alternate 0,1,0,1,0,1. Each rvalid follows its gnt by 1 cycle with mem_rdata passed through.
- Lock with forced release: MAX_LOCK = 4, r1 reads with lock = 1, r0 also requesting → r1 granted 4 consecutive cycles, then r0 is granted in cycle 5.
- Voluntary release: r0 locks and gets 2 beats, then drops req with r1 waiting → no grant that cycle (OWN0 → IDLE). r1 is granted the next cycle.
- Write path: r1 writes 0xBEEF to 0x1234 → same cycle mem_we = 1, mem_addr = 0x1234, mem_wdata = 0xBEEF, r1_gnt = 1. No r1_rvalid follows.
- Reset mid-lock: rst asserted in OWN1 with lock_cnt = 2 → after rst, fsm = IDLE and r0 wins the first contended cycle.
